// File: rtl/mac_seq_driver.sv
// Operand FIFO plus clear/run/capture sequencer in front of the signed MAC.
// Presents each vector's accumulated dot product on a valid/ready port.
module mac_seq_driver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_w,
  input  logic [WIDTH-1:0]   in_x,
  input  logic               in_last,
  output logic               mac_clr,
  output logic               mac_en,
  output logic [WIDTH-1:0]   mac_w,
  output logic [WIDTH-1:0]   mac_x,
  input  logic [2*WIDTH-1:0] mac_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic [LEN_W-1:0]   res_len
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    CAPT,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mem_w [DEPTH];
  logic [WIDTH-1:0] mem_x [DEPTH];
  logic [DEPTH-1:0] mem_l;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [LEN_W-1:0] cnt;
  logic             empty, full;
  logic             push, pop;
  logic             head_l;

  // Extra pointer bit separates full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = mac_en;

  assign mac_w  = mem_w[rd_ptr[AW-1:0]];
  assign mac_x  = mem_x[rd_ptr[AW-1:0]];
  assign head_l = mem_l[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_w[wr_ptr[AW-1:0]] <= in_w;
      mem_x[wr_ptr[AW-1:0]] <= in_x;
      mem_l[wr_ptr[AW-1:0]] <= in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_len   <= '0;
    end else begin
      state <= state_nxt;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (state == CLEAR)
        cnt <= '0;
      else if (pop)
        cnt <= cnt + 1'b1;
      // mac_out already holds the last term here
      if (state == CAPT) begin
        res_data  <= mac_out;
        res_len   <= cnt;
        res_valid <= 1'b1;
      end else if (state == HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mac_clr   = rst;
    mac_en    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty)
          state_nxt = CLEAR;
      end
      CLEAR: begin
        mac_clr   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        mac_en = !empty && !rst;
        if (!empty && head_l)
          state_nxt = CAPT;
      end
      CAPT: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (res_ready)
          state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_seq_driver.sv
// Directed bench for mac_seq_driver with a behavioural 16-bit MAC model.
// Checks cycle timing, stalls, wrap, backpressure, FIFO full and reset.
module tb_mac_seq_driver;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LEN_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_w, in_x;
  logic               in_last;
  logic               mac_clr, mac_en;
  logic [WIDTH-1:0]   mac_w, mac_x;
  logic [2*WIDTH-1:0] mac_out;
  logic               res_valid, res_ready;
  logic [2*WIDTH-1:0] res_data;
  logic [LEN_W-1:0]   res_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_seq_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_w(in_w), .in_x(in_x), .in_last(in_last),
    .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_w(mac_w), .mac_x(mac_x), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_len(res_len)
  );

  // Reference MAC: signed product, accumulation wraps at 16 bits
  logic signed [2*WIDTH-1:0] acc;
  logic signed [2*WIDTH-1:0] prod;
  assign prod = $signed({{WIDTH{mac_w[WIDTH-1]}}, mac_w}) *
                $signed({{WIDTH{mac_x[WIDTH-1]}}, mac_x});
  always_ff @(posedge clk) begin
    if (mac_clr)
      acc <= '0;
    else if (mac_en)
      acc <= acc + prod;
  end
  assign mac_out = acc;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input int x, input logic l);
    in_valid = 1'b1;
    in_w     = WIDTH'(w);
    in_x     = WIDTH'(x);
    in_last  = l;
  endtask

  task automatic push(input string tag, input int w, input int x,
                      input logic l);
    int n;
    logic ok;
    drive(w, x, l);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 30) begin
      ok = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!ok)
      chk({tag, "_push_timeout"}, 0, 1);
  endtask

  task automatic wait_result(input string tag, input int d, input int len);
    int n;
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(res_valid), 1);
    chk({tag, "_data"}, $signed(res_data), d);
    chk({tag, "_len"}, 32'(res_len), len);
  endtask

  initial begin
    int idx;
    logic acc_now;
    rst = 1'b1; in_valid = 1'b0; in_w = '0; in_x = '0;
    in_last = 1'b0; res_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_mac_clr", 32'(mac_clr), 1);
    chk("rst_mac_en", 32'(mac_en), 0);
    rst = 1'b0;
    tick();
    chk("init_valid", 32'(res_valid), 0);
    chk("init_data", $signed(res_data), 0);
    chk("init_len", 32'(res_len), 0);
    chk("init_in_ready", 32'(in_ready), 1);
    chk("init_mac_clr", 32'(mac_clr), 0);

    // Two-term vector, exact cycle timing
    drive(-3, 2, 1'b0);
    tick();
    drive(5, -4, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t1_clr", 32'(mac_clr), 1);
    chk("t1_clr_en", 32'(mac_en), 0);
    tick();
    chk("t1_en0", 32'(mac_en), 1);
    chk("t1_clr0", 32'(mac_clr), 0);
    chk("t1_w0", $signed(mac_w), -3);
    tick();
    chk("t1_en1", 32'(mac_en), 1);
    chk("t1_x1", $signed(mac_x), -4);
    tick();
    chk("t1_capt_en", 32'(mac_en), 0);
    chk("t1_capt_valid", 32'(res_valid), 0);
    tick();
    chk("t1_valid", 32'(res_valid), 1);
    chk("t1_data", $signed(res_data), -26);
    chk("t1_len", 32'(res_len), 2);
    tick();
    chk("t1_drop", 32'(res_valid), 0);

    // Bubble between terms
    push("t2a", 6, -8, 1'b0);
    tick();
    tick();
    tick();
    chk("t2_gap_en", 32'(mac_en), 0);
    push("t2b", 1, 1, 1'b1);
    wait_result("t2", -47, 2);
    tick();

    // 16-bit wrap
    push("t3a", -128, -128, 1'b0);
    push("t3b", -128, -128, 1'b1);
    wait_result("t3", -32768, 2);
    tick();

    // Backpressure with a queued second vector
    res_ready = 1'b0;
    push("t4a", 3, 3, 1'b1);
    wait_result("t4", 9, 1);
    push("t4b", 2, 3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(res_valid), 1);
      chk("t4_hold_data", $signed(res_data), 9);
      chk("t4_hold_clr", 32'(mac_clr), 0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("t4_drop", 32'(res_valid), 0);
    wait_result("t4b", 6, 1);
    tick();

    // FIFO full while the result port is stalled
    res_ready = 1'b0;
    push("t5blk", 1, 2, 1'b1);
    wait_result("t5blk", 2, 1);
    idx = 1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(idx, 1, (idx == 3) ? 1'b1 : 1'b0);
      acc_now = in_ready;
      tick();
      if (acc_now)
        idx++;
    end
    in_valid = 1'b0;
    chk("t5_accepted", idx - 1, DEPTH);
    chk("t5_full", 32'(in_ready), 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    push("t5e5", 5, 1, 1'b0);
    push("t5e6", 6, 1, 1'b1);
    wait_result("t5v1", 6, 3);
    res_ready = 1'b1;
    tick();
    chk("t5_drop", 32'(res_valid), 0);
    wait_result("t5v2", 15, 3);
    tick();

    // Reset during the second term of a four-term vector
    drive(1, 1, 1'b0);
    tick();
    tick();
    tick();
    drive(1, 1, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t6_run_en", 32'(mac_en), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_clr", 32'(mac_clr), 1);
    chk("t6_rst_ready", 32'(in_ready), 0);
    chk("t6_rst_en", 32'(mac_en), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_valid", 32'(res_valid), 0);
    chk("t6_empty_en", 32'(mac_en), 0);
    tick();
    chk("t6_idle_clr", 32'(mac_clr), 0);
    push("t6", 4, -5, 1'b1);
    wait_result("t6", -20, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
